// File: rtl/reg_file_sb.sv
// Register file with write-back scoreboard: three combinational read ports, one clocked
// write port, per-register busy bits. Define REG_FILE_SB_BYPASS_EN for write-to-read forwarding.
module reg_file_sb #(
  parameter int DATA_W   = 16,
  parameter int NUM_REG  = 16,
  parameter int ADDR_W   = $clog2(NUM_REG),
  parameter int SP_IDX   = 2,
  parameter     SP_RESET = 16'hFFFC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic [DATA_W-1:0] dbg_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_rd,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              hazard,
  output logic [NUM_REG-1:0] busy_vec
);

  localparam logic [DATA_W-1:0] SP_INIT = DATA_W'(SP_RESET);

  logic [DATA_W-1:0]  regs [NUM_REG];
  logic [NUM_REG-1:0] busy_q;
  logic               wr_live;

  assign wr_live = wr_en && (wr_addr != '0);

  // NOTE: the whole array is reset here because the architectural SP value and
  // zeroed registers are visible state; a plain RAM would normally skip this.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REG; i++) regs[i] <= '0;
      regs[SP_IDX] <= SP_INIT;
    end else if (wr_live) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // A younger issue to the same register outranks the retiring writeback.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q[0] <= 1'b0;
      for (int i = 1; i < NUM_REG; i++) begin
        if (iss_en && (iss_rd == ADDR_W'(i)))
          busy_q[i] <= 1'b1;
        else if (wr_en && (wr_addr == ADDR_W'(i)))
          busy_q[i] <= 1'b0;
      end
    end
  end

  logic rs1_fwd, rs2_fwd, dbg_fwd;

`ifdef REG_FILE_SB_BYPASS_EN
  assign rs1_fwd = wr_live && (wr_addr == rs1_addr);
  assign rs2_fwd = wr_live && (wr_addr == rs2_addr);
  assign dbg_fwd = wr_live && (wr_addr == dbg_addr);
`else
  assign rs1_fwd = 1'b0;
  assign rs2_fwd = 1'b0;
  assign dbg_fwd = 1'b0;
`endif

  // Index 0 reads as zero no matter what the array or the write port hold.
  assign rs1_data = (rs1_addr == '0) ? '0 : (rs1_fwd ? wr_data : regs[rs1_addr]);
  assign rs2_data = (rs2_addr == '0) ? '0 : (rs2_fwd ? wr_data : regs[rs2_addr]);
  assign dbg_data = (dbg_addr == '0) ? '0 : (dbg_fwd ? wr_data : regs[dbg_addr]);

  assign rs1_busy = busy_q[rs1_addr] & ~rs1_fwd;
  assign rs2_busy = busy_q[rs2_addr] & ~rs2_fwd;
  assign hazard   = rs1_busy | rs2_busy;
  assign busy_vec = busy_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed table-driven bench for reg_file_sb; expectations follow REG_FILE_SB_BYPASS_EN.
module tb_reg_file_sb;

`ifdef REG_FILE_SB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  rs1_addr, rs2_addr, dbg_addr, wr_addr, iss_rd;
  logic [15:0] rs1_data, rs2_data, dbg_data, wr_data;
  logic        wr_en, iss_en, rs1_busy, rs2_busy, hazard;
  logic [15:0] busy_vec;

  int checks = 0;
  int errors = 0;

  reg_file_sb dut (
    .clk(clk), .reset(reset),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .dbg_addr(dbg_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .dbg_data(dbg_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_rd(iss_rd),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .hazard(hazard),
    .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          we;
    logic [3:0]  wa;
    logic [15:0] wd;
    bit          ie;
    logic [3:0]  ir;
    logic [3:0]  a1, a2, ad;
    logic [15:0] e1, e2, ed, eb;
    bit          eh;
  } vec_t;

  function automatic vec_t mk(bit rst, bit we, logic [3:0] wa, logic [15:0] wd,
                              bit ie, logic [3:0] ir,
                              logic [3:0] a1, logic [3:0] a2, logic [3:0] ad,
                              logic [15:0] e1, logic [15:0] e2, logic [15:0] ed,
                              logic [15:0] eb, bit eh);
    vec_t v;
    v.rst = rst; v.we = we; v.wa = wa; v.wd = wd; v.ie = ie; v.ir = ir;
    v.a1 = a1; v.a2 = a2; v.ad = ad;
    v.e1 = e1; v.e2 = e2; v.ed = ed; v.eb = eb; v.eh = eh;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; iss_en = 1'b0; iss_rd = '0;
  endtask

  vec_t vecs[$];

  initial begin
    // Outputs are checked combinationally, i.e. against state before the vector's edge.
    vecs.push_back(mk(0,0,0,16'h0000,0,0, 0,0,0, 16'h0000,16'h0000,16'h0000, 16'h0000,0));
    vecs.push_back(mk(0,0,0,16'h0000,0,0, 2,5,0, 16'hFFFC,16'h0000,16'h0000, 16'h0000,0));
    vecs.push_back(mk(0,1,7,16'hA5A5,0,0, 7,2,7, BYP ? 16'hA5A5 : 16'h0000, 16'hFFFC,
                      BYP ? 16'hA5A5 : 16'h0000, 16'h0000,0));
    vecs.push_back(mk(0,1,0,16'h1234,0,0, 7,0,0, 16'hA5A5,16'h0000,16'h0000, 16'h0000,0));
    vecs.push_back(mk(0,0,0,16'h0000,0,0, 0,0,7, 16'h0000,16'h0000,16'hA5A5, 16'h0000,0));
    vecs.push_back(mk(0,1,3,16'hBEEF,0,0, 7,3,3, 16'hA5A5, BYP ? 16'hBEEF : 16'h0000,
                      BYP ? 16'hBEEF : 16'h0000, 16'h0000,0));
    vecs.push_back(mk(0,0,0,16'h0000,0,0, 3,3,2, 16'hBEEF,16'hBEEF,16'hFFFC, 16'h0000,0));
    vecs.push_back(mk(0,0,0,16'h0000,1,4, 4,0,0, 16'h0000,16'h0000,16'h0000, 16'h0000,0));
    vecs.push_back(mk(0,0,0,16'h0000,0,0, 4,7,0, 16'h0000,16'hA5A5,16'h0000, 16'h0010,1));
    vecs.push_back(mk(0,1,4,16'h4444,0,0, 4,0,0, BYP ? 16'h4444 : 16'h0000, 16'h0000,16'h0000,
                      16'h0010, !BYP));
    vecs.push_back(mk(0,0,0,16'h0000,0,0, 4,0,0, 16'h4444,16'h0000,16'h0000, 16'h0000,0));
    vecs.push_back(mk(0,1,6,16'h6666,1,6, 6,4,0, BYP ? 16'h6666 : 16'h0000, 16'h4444,16'h0000,
                      16'h0000,0));
    vecs.push_back(mk(0,0,0,16'h0000,0,0, 6,0,0, 16'h6666,16'h0000,16'h0000, 16'h0040,1));
    vecs.push_back(mk(0,0,0,16'h0000,1,0, 0,6,0, 16'h0000,16'h6666,16'h0000, 16'h0040,1));
    vecs.push_back(mk(0,0,0,16'h0000,0,0, 0,0,0, 16'h0000,16'h0000,16'h0000, 16'h0040,0));
    vecs.push_back(mk(0,1,6,16'h0606,0,0, 6,0,0, BYP ? 16'h0606 : 16'h6666, 16'h0000,16'h0000,
                      16'h0040, !BYP));
    vecs.push_back(mk(0,1,9,16'h00FF,1,4, 9,0,0, BYP ? 16'h00FF : 16'h0000, 16'h0000,16'h0000,
                      16'h0000,0));
    vecs.push_back(mk(0,0,0,16'h0000,1,9, 9,4,0, 16'h00FF,16'h4444,16'h0000, 16'h0010,1));
    vecs.push_back(mk(1,1,9,16'hDEAD,1,5, 9,4,2, BYP ? 16'hDEAD : 16'h00FF, 16'h4444,16'hFFFC,
                      16'h0210,1));
    vecs.push_back(mk(0,0,0,16'h0000,0,0, 9,4,2, 16'h0000,16'h0000,16'hFFFC, 16'h0000,0));
    vecs.push_back(mk(0,0,0,16'h0000,0,0, 7,3,6, 16'h0000,16'h0000,16'h0000, 16'h0000,0));

    idle();
    reset = 1'b1;
    rs1_addr = '0; rs2_addr = '0; dbg_addr = '0;
    tick();

    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst; wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
      iss_en = vecs[i].ie; iss_rd = vecs[i].ir;
      rs1_addr = vecs[i].a1; rs2_addr = vecs[i].a2; dbg_addr = vecs[i].ad;
      #3;
      check($sformatf("v%0d rs1_data", i), 32'(rs1_data), 32'(vecs[i].e1));
      check($sformatf("v%0d rs2_data", i), 32'(rs2_data), 32'(vecs[i].e2));
      check($sformatf("v%0d dbg_data", i), 32'(dbg_data), 32'(vecs[i].ed));
      check($sformatf("v%0d busy_vec", i), 32'(busy_vec), 32'(vecs[i].eb));
      check($sformatf("v%0d hazard", i), 32'(hazard), 32'(vecs[i].eh));
      tick();
    end

    // Fill every register while issuing to it in the same cycle: all must end busy.
    for (int i = 1; i < 16; i++) begin
      wr_en = 1'b1; wr_addr = 4'(i); wr_data = 16'(i * 16'h0101);
      iss_en = 1'b1; iss_rd = 4'(i);
      tick();
    end
    idle();
    #3;
    check("fill busy_vec", 32'(busy_vec), 32'h0000_FFFE);
    for (int i = 0; i < 16; i++) begin
      rs1_addr = 4'(i); rs2_addr = 4'(15 - i); dbg_addr = 4'(i);
      #1;
      check($sformatf("fill rs1 r%0d", i), 32'(rs1_data), (i == 0) ? 32'h0 : 32'(i * 16'h0101));
      check($sformatf("fill rs2 r%0d", 15 - i), 32'(rs2_data),
            (i == 15) ? 32'h0 : 32'((15 - i) * 16'h0101));
      check($sformatf("fill rs1_busy r%0d", i), 32'(rs1_busy), (i == 0) ? 32'h0 : 32'h1);
    end

    // Drain the scoreboard by writebacks alone.
    for (int i = 1; i < 16; i++) begin
      wr_en = 1'b1; wr_addr = 4'(i); wr_data = 16'h0;
      tick();
    end
    idle();
    rs1_addr = 4'd5; rs2_addr = 4'd15;
    #3;
    check("drain busy_vec", 32'(busy_vec), 32'h0);
    check("drain hazard", 32'(hazard), 32'h0);
    check("drain rs1_data", 32'(rs1_data), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
